ad9245_capture_ctrl: RTL
========================

Name: ad9245_capture_ctrl

Overview:
Capture sequencer for the AD9245 14-bit ADC path. It is armed and configured over an Avalon-MM slave. It waits for a software or threshold trigger, then captures a programmed number of optionally decimated samples into an internal FIFO. The CPU drains the FIFO through a data register. The block sits between the ADC pins and the Avalon bus, replacing direct free-running sample reads.

Parameters:
FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW = 512 words
COUNT_W, 16, width of the sample-count register
DECIM_W, 8, width of the decimation register

Ports:
clk  input  1  Avalon clock; the ADC clock source is the same clock
reset_n  input  1  asynchronous active-low reset
ad_clk_source  input  1  ADC clock source
ad_clk  output  1  ADC sample clock, driven combinationally from ad_clk_source
ad_data  input  14  ADC sample data
chipselect  input  1  Avalon chipselect
address  input  3  Avalon word address
read  input  1  Avalon read
write  input  1  Avalon write
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
irq  output  1  level interrupt = done & irq_en

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - All registers clear: readdata=0, irq=0, state=IDLE, FIFO empty.
  - Status flags=0, COUNT=0, DECIM=0, THRESH=0, CTRL=0.
- Register map (word address), accessed only when chipselect=1:
  - 0 CTRL RW. Bit0 START, write-1, self-clearing, reads 0. Bit1 ABORT, write-1, reads 0. Bit2 TRIG_MODE (0 immediate, 1 threshold). Bit3 IRQ_EN.
  - 1 STATUS RO. Bit0 busy. Bit1 done (sticky). Bit2 overflow (sticky). Bits[31:16] FIFO level, zero-extended.
  - 2 COUNT RW, COUNT_W bits. 3 DECIM RW, DECIM_W bits. 4 THRESH RW, 14 bits, unsigned.
  - 5 DATA RO. Returns {empty_n, 17'h0, sample[13:0]} and pops one word if the FIFO is non-empty. If empty, returns 0 and does not pop.
  - Addresses 6-7 read 0; writes to them are ignored.
- Read latency is 1 cycle: readdata updates on the clk edge after chipselect&read and holds otherwise.
- ADC input path: ad_data is registered once into ad_q. The trigger compare and FIFO push use ad_q, so samples are 1 cycle late relative to the pins.
- State machine:
  - IDLE: START with COUNT≠0 clears done, overflow and the FIFO. It loads remaining=COUNT and decim_cnt=0. Next state is WAIT_TRIG. START with COUNT=0 is ignored.
  - WAIT_TRIG: TRIG_MODE=0 goes to CAPTURE next cycle. TRIG_MODE=1 goes to CAPTURE on the first cycle where ad_q ≥ THRESH and the previous ad_q < THRESH (rising crossing).
  - CAPTURE: every cycle with decim_cnt==0 is a keep cycle.
    - On a keep cycle, ad_q is pushed and remaining decrements.
    - decim_cnt counts 0..DECIM and wraps to 0, so DECIM=0 keeps every sample.
    - When remaining reaches 0 after a push, next state is DONE.
  - DONE: sets done=1 for one cycle, then returns to IDLE. done stays set until the next accepted START.
- busy = 1 in WAIT_TRIG and CAPTURE.
- START while busy is ignored.
- ABORT in any state returns to IDLE next cycle. It does not set done and keeps FIFO contents. ABORT beats START when both are written in the same cycle.
- FIFO full on a keep cycle: the sample is dropped, overflow is set, and remaining still decrements, so capture length is deterministic.
- Push and pop in the same cycle:
  - Full: pop frees a slot and the push succeeds; level is unchanged; no overflow.
  - Empty: the pop returns empty and only the push takes effect.
- The FIFO read pointer and write pointer wrap modulo depth. The level counter is FIFO_AW+1 bits wide.
- Register writes to COUNT, DECIM and THRESH while busy take effect at the next START, except THRESH, which applies immediately.
- Async reset mid-capture aborts everything. No partial state survives.

Decomposition:
- Shared package ad9245_pkg holds:
  - Register address constants: ADDR_CTRL=0 … ADDR_DATA=5.
  - CTRL/STATUS bit index constants.
  - State enum: IDLE, WAIT_TRIG, CAPTURE, DONE.
  - ADC width constant (14).
- One natural sub-module, ad9245_sync_fifo: single-clock FIFO, 14-bit data, parameter FIFO_AW, with push/pop/full/empty/level and the simultaneous push+pop rule above.

Test Plan:
- COUNT=8, DECIM=0, TRIG_MODE=0, ramp on ad_data, START → done=1, level=8. Eight DATA reads return bit31=1 with consecutive ramp values offset by the 1-cycle input register. A ninth read returns 0.
- COUNT=4, DECIM=2, ramp 0,1,2,… → FIFO holds 0,3,6,9 relative to the capture start sample.
- TRIG_MODE=1, THRESH=0x1000, ad_data held at 0x0800 for 20 cycles then stepped to 0x1200 → busy stays high with no pushes until the step. The first captured sample is 0x1200.
- COUNT=600, no reads → level saturates at 512, overflow=1, done=1 after exactly 600 keep cycles.
- Mid-capture ABORT with START written in the same cycle → IDLE, busy=0, done=0, FIFO keeps already-captured samples.
- Assert reset_n low during CAPTURE → all outputs and STATUS read 0 after release. irq=0 even with IRQ_EN previously set.

Source files
------------

// File: rtl/ad9245_pkg.sv
// Shared constants and types for the AD9245 capture sequencer.
package ad9245_pkg;

    localparam int ADC_W = 14;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_COUNT  = 3'd2;
    localparam logic [2:0] ADDR_DECIM  = 3'd3;
    localparam logic [2:0] ADDR_THRESH = 3'd4;
    localparam logic [2:0] ADDR_DATA   = 3'd5;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_TRIG_MODE = 2;
    localparam int CTRL_IRQ_EN    = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_LEVEL_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        DONE
    } cap_state_e;

endpackage

// File: rtl/ad9245_sync_fifo.sv
// Single-clock sample FIFO. A pop on a full FIFO makes room for a push in
// the same cycle; a pop on an empty FIFO is ignored.
module ad9245_sync_fifo
    import ad9245_pkg::*;
#(
    parameter int FIFO_AW = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [ADC_W-1:0]   wdata,
    output logic [ADC_W-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0]   LVL_ONE = 1;

    logic [ADC_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   level_q;
    logic               do_push;
    logic               do_pop;

    // Level never exceeds DEPTH, so its top bit alone marks full.
    assign full    = level_q[FIFO_AW];
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and level bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sample storage; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ad9245_capture_ctrl.sv
// AD9245 capture sequencer: Avalon-MM configured, triggered capture of
// optionally decimated ADC samples into a FIFO drained via the DATA register.
module ad9245_capture_ctrl
    import ad9245_pkg::*;
#(
    parameter int FIFO_AW = 9,
    parameter int COUNT_W = 16,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ad_clk_source,
    output logic               ad_clk,
    input  logic [ADC_W-1:0]   ad_data,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq
);

    localparam logic [COUNT_W-1:0] CNT_ONE = 1;
    localparam logic [DECIM_W-1:0] DEC_ONE = 1;

    cap_state_e state_q, state_d;

    logic               trig_mode_q;
    logic               irq_en_q;
    logic [COUNT_W-1:0] count_q;
    logic [DECIM_W-1:0] decim_q;
    logic [ADC_W-1:0]   thresh_q;

    logic               done_q;
    logic               ovf_q;
    logic [COUNT_W-1:0] remaining_q;
    logic [DECIM_W-1:0] decim_cnt_q;
    logic [DECIM_W-1:0] decim_lat_q;

    logic [ADC_W-1:0]   ad_q;
    logic [ADC_W-1:0]   ad_prev_q;

    logic               wr_en, rd_en;
    logic               start_req, abort_req;
    logic               accept_start, keep, trig_hit, busy;
    logic               fifo_pop, fifo_full, fifo_empty;
    logic [ADC_W-1:0]   fifo_rdata;
    logic [FIFO_AW:0]   fifo_level;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign ad_clk       = ad_clk_source;
    assign wr_en        = chipselect && write;
    assign rd_en        = chipselect && read;
    assign start_req    = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START];
    assign abort_req    = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
    assign fifo_pop     = rd_en && (address == ADDR_DATA);
    assign trig_hit     = (ad_q >= thresh_q) && (ad_prev_q < thresh_q);
    assign busy         = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign irq          = done_q && irq_en_q;
    assign unused_wdata = ^writedata;

    // Register the ADC pins once; the previous sample feeds the edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ad_q      <= '0;
            ad_prev_q <= '0;
        end else begin
            ad_q      <= ad_data;
            ad_prev_q <= ad_q;
        end
    end

    // Configuration registers; THRESH is used live, COUNT/DECIM latch at START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_mode_q <= 1'b0;
            irq_en_q    <= 1'b0;
            count_q     <= '0;
            decim_q     <= '0;
            thresh_q    <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    trig_mode_q <= writedata[CTRL_TRIG_MODE];
                    irq_en_q    <= writedata[CTRL_IRQ_EN];
                end
                ADDR_COUNT:  count_q  <= writedata[COUNT_W-1:0];
                ADDR_DECIM:  decim_q  <= writedata[DECIM_W-1:0];
                ADDR_THRESH: thresh_q <= writedata[ADC_W-1:0];
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; ABORT overrides every transition including START.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        keep         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && !abort_req && (count_q != '0)) begin
                    state_d      = WAIT_TRIG;
                    accept_start = 1'b1;
                end
            end
            WAIT_TRIG: begin
                if (!trig_mode_q || trig_hit) state_d = CAPTURE;
            end
            CAPTURE: begin
                keep = (decim_cnt_q == '0);
                if (keep && (remaining_q == CNT_ONE)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_req) state_d = IDLE;
    end

    // Capture bookkeeping: sticky flags, remaining count and decimation phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
            decim_cnt_q <= '0;
            decim_lat_q <= '0;
        end else if (accept_start) begin
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            remaining_q <= count_q;
            decim_cnt_q <= '0;
            decim_lat_q <= decim_q;
        end else begin
            if ((state_q == CAPTURE) && (state_d == DONE)) done_q <= 1'b1;
            // A pop in the same cycle frees a slot, so that is not an overflow.
            if (keep && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            // Remaining decrements even when the sample is dropped.
            if (keep) remaining_q <= remaining_q - CNT_ONE;
            if (state_q == CAPTURE) begin
                decim_cnt_q <= (decim_cnt_q == decim_lat_q) ? '0 : decim_cnt_q + DEC_ONE;
            end
        end
    end

    ad9245_sync_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept_start),
        .push    (keep),
        .pop     (fifo_pop),
        .wdata   (ad_q),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Read-data mux; unmapped addresses and an empty DATA read return zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL: begin
                rd_mux[CTRL_TRIG_MODE] = trig_mode_q;
                rd_mux[CTRL_IRQ_EN]    = irq_en_q;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]                        = busy;
                rd_mux[STAT_DONE]                        = done_q;
                rd_mux[STAT_OVF]                         = ovf_q;
                rd_mux[STAT_LEVEL_LSB +: 16]             = 16'(fifo_level);
            end
            ADDR_COUNT:  rd_mux[COUNT_W-1:0] = count_q;
            ADDR_DECIM:  rd_mux[DECIM_W-1:0] = decim_q;
            ADDR_THRESH: rd_mux[ADC_W-1:0]   = thresh_q;
            ADDR_DATA: begin
                if (!fifo_empty) rd_mux = {1'b1, 17'h0, fifo_rdata};
            end
            default: ;
        endcase
    end

    // One-cycle registered read data, held between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   readdata <= '0;
        else if (rd_en) readdata <= rd_mux;
    end

endmodule
